// File: rtl/icache_ctrl_sa.sv
// Read-only set-associative instruction cache controller.
// Tag, valid, LRU and data arrays are held in registers. One request is
// outstanding at a time. A miss fetches the whole line as BEATS memory
// beats, always starting from beat 0, and then answers from the fill buffer.
module icache_ctrl_sa #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_W      = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic              cpu_req_valid,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_res_data,
    output logic              cpu_res_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    input  logic [MEM_W-1:0]  mem_data,
    input  logic              mem_ready,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int BEATS  = LINE_W / MEM_W;
    localparam int WPB    = MEM_W / DATA_W;
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]  r_data  [WAYS][SETS];
    logic [SETS-1:0]    r_valid [WAYS];
    logic [SETS-1:0]    r_lru;            // per set: way to evict next
    logic [ADDR_W-1:0]  r_addr;
    logic               r_victim;
    logic [BEAT_W-1:0]  r_beat;
    logic [LINE_W-1:0]  r_fill;
    logic               r_flush_pend;
    logic [DATA_W-1:0]  r_res_data;
    logic               r_res_ready;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_valid;
    logic [15:0]        r_hit_cnt;
    logic [15:0]        r_miss_cnt;

    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_idx;
    logic [OFF_W-1:0]   w_off;
    logic [TAG_W-1:0]   w_f_tag;
    logic [IDX_W-1:0]   w_f_idx;
    logic [OFF_W-1:0]   w_f_off;
    logic               w_hit;
    logic               w_hit_way;
    logic [LINE_W-1:0]  w_hit_line;
    logic               w_inv;
    logic               w_inv_way;
    logic               w_victim;
    logic               w_last;
    logic [LINE_W-1:0]  w_fill_next;

    // Pick word 'off' out of a cache line.
    function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        word_sel = line[off*DATA_W +: DATA_W];
    endfunction

    assign w_tag   = cpu_req_addr[ADDR_W-1 -: TAG_W];
    assign w_idx   = cpu_req_addr[OFF_W +: IDX_W];
    assign w_off   = cpu_req_addr[OFF_W-1:0];
    assign w_f_tag = r_addr[ADDR_W-1 -: TAG_W];
    assign w_f_idx = r_addr[OFF_W +: IDX_W];
    assign w_f_off = r_addr[OFF_W-1:0];
    assign w_last  = (r_beat == BEAT_W'(BEATS - 1));

    // Tag lookup of the incoming address and victim choice (lowest invalid way, else LRU).
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = 1'b0;
        w_hit_line = '0;
        w_inv      = 1'b0;
        w_inv_way  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_way  = 1'(w);
                w_hit_line = r_data[w][w_idx];
            end else begin
                w_hit      = w_hit;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_inv_way = (!r_valid[w][w_idx]) ? 1'(w) : w_inv_way;
            w_inv     = w_inv | !r_valid[w][w_idx];
        end
        w_victim = w_inv ? w_inv_way : ((WAYS == 2) ? r_lru[w_idx] : 1'b0);
    end

    // Fill buffer with the beat currently on mem_data merged into its slot.
    always_comb begin
        w_fill_next = r_fill;
        for (int b = 0; b < BEATS; b++) begin
            w_fill_next[b*MEM_W +: MEM_W] = (BEAT_W'(b) == r_beat) ? mem_data
                                                                    : r_fill[b*MEM_W +: MEM_W];
        end
    end

    // Control FSM, cache arrays, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            r_lru        <= '0;
            r_addr       <= '0;
            r_victim     <= 1'b0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_res_data   <= '0;
            r_res_ready  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_valid  <= 1'b0;
            r_hit_cnt    <= 16'd0;
            r_miss_cnt   <= 16'd0;
        end else begin
            r_res_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        // flush takes priority over a request in the same cycle
                        for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                        r_lru        <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (cpu_req_valid) begin
                        r_addr <= cpu_req_addr;
                        if (w_hit) begin
                            r_res_ready <= 1'b1;
                            r_res_data  <= word_sel(w_hit_line, w_off);
                            r_hit_cnt   <= (r_hit_cnt == 16'hFFFF) ? r_hit_cnt : r_hit_cnt + 16'd1;
                            if (WAYS == 2) r_lru[w_idx] <= ~w_hit_way;
                        end else begin
                            r_miss_cnt  <= (r_miss_cnt == 16'hFFFF) ? r_miss_cnt : r_miss_cnt + 16'd1;
                            r_victim    <= w_victim;
                            r_beat      <= '0;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_state     <= S_FILL;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (mem_ready) begin
                        r_fill <= w_fill_next;
                        if (w_last) begin
                            r_mem_valid                <= 1'b0;
                            r_tag[r_victim][w_f_idx]   <= w_f_tag;
                            r_data[r_victim][w_f_idx]  <= w_fill_next;
                            r_valid[r_victim][w_f_idx] <= 1'b1;
                            if (WAYS == 2) r_lru[w_f_idx] <= ~r_victim;
                            r_res_ready <= 1'b1;
                            r_res_data  <= word_sel(w_fill_next, w_f_off);
                            r_state     <= S_RESPOND;
                        end else begin
                            r_beat     <= r_beat + BEAT_W'(1);
                            r_mem_addr <= r_mem_addr + ADDR_W'(WPB);
                        end
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_RESPOND: begin
                    // a flush seen during the fill is applied as we return to idle
                    if (flush || r_flush_pend) begin
                        for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                        r_lru <= '0;
                    end else begin
                        r_lru <= r_lru;
                    end
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_res_data  = r_res_data;
    assign cpu_res_ready = r_res_ready;
    assign mem_req_addr  = r_mem_addr;
    assign mem_req_valid = r_mem_valid;
    assign mem_req_rw    = 1'b0;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_icache_ctrl_sa.sv
// Bench for icache_ctrl_sa: directed steps followed by randomized requests,
// checked against a recency-list cache model and a static memory image.
module tb_icache_ctrl_sa;
    localparam int BEATS = 2;
    localparam int WPB   = 2;
    localparam int WAYS  = 2;
    localparam int SETS  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_req_addr;
    logic        cpu_req_valid;
    logic        flush;
    logic [15:0] cpu_res_data;
    logic        cpu_res_ready;
    logic [15:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_rw;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int vectors = 0;
    int errors  = 0;

    // model: per set, resident tags ordered most-recent first
    logic [9:0] m_tags [SETS][WAYS];
    int         m_cnt  [SETS];
    int         exp_hit;
    int         exp_miss;

    icache_ctrl_sa dut (
        .clk(clk), .rst(rst),
        .cpu_req_addr(cpu_req_addr), .cpu_req_valid(cpu_req_valid), .flush(flush),
        .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
        .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
    endtask

    task automatic model_access(input logic [15:0] a, output bit hit);
        int          idx;
        int          pos;
        logic [9:0]  tag;
        idx = int'(a[5:2]);
        tag = a[15:6];
        pos = -1;
        for (int i = 0; i < m_cnt[idx]; i++) if (m_tags[idx][i] == tag) pos = i;
        hit = (pos >= 0);
        if (!hit) begin
            pos = (m_cnt[idx] < WAYS) ? m_cnt[idx] : WAYS - 1;
            if (m_cnt[idx] < WAYS) m_cnt[idx]++;
            if (exp_miss < 65535) exp_miss++;
        end else begin
            if (exp_hit < 65535) exp_hit++;
        end
        for (int i = pos; i > 0; i--) m_tags[idx][i] = m_tags[idx][i-1];
        m_tags[idx][0] = tag;
    endtask

    // mode 0: mem_ready always 1; 1: random mem_ready; 2: first 5 beat cycles stalled
    task automatic do_req(input logic [15:0] a, input int mode, input bit flush_mid);
        bit          hit;
        bit          done;
        bit          flushed;
        int          n;
        int          beats;
        int          stall_left;
        logic [15:0] base;
        model_access(a, hit);
        base = {a[15:2], 2'b00};
        @(negedge clk);
        cpu_req_addr  = a;
        cpu_req_valid = 1'b1;
        mem_ready     = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 1; beats = 0; done = 1'b0; flushed = 1'b0;
        stall_left = (mode == 2) ? 5 : 0;
        while (!done && n <= 200) begin
            flush = 1'b0;
            if (cpu_res_ready) begin
                done      = 1'b1;
                mem_ready = 1'b0;
            end else begin
                if (mem_req_valid) begin
                    check("mem_addr", 32'(mem_req_addr), 32'(base + 16'(beats * WPB)));
                    mem_data = {mem_word(mem_req_addr + 16'd1), mem_word(mem_req_addr)};
                    if (mode == 2 && stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else if (mode == 1) begin
                        mem_ready = 1'($urandom_range(0, 1));
                    end else begin
                        mem_ready = 1'b1;
                    end
                    if (mem_ready) beats++;
                end else begin
                    mem_ready = 1'b0;
                end
                if (flush_mid && n == 1) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
                @(negedge clk);
                n++;
            end
        end
        flush = 1'b0;
        check("res_seen", 32'(done), 32'd1);
        if (hit) begin
            check("hit_lat", 32'(n), 32'd1);
            check("hit_beats", 32'(beats), 32'd0);
        end else begin
            check("fill_beats", 32'(beats), 32'(BEATS));
            if (mode == 0) check("miss_lat", 32'(n), 32'(1 + BEATS));
            if (mode == 2) check("stall_lat", 32'(n), 32'(1 + BEATS + 5));
        end
        check("res_data", 32'(cpu_res_data), 32'(mem_word(a)));
        check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
        check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
        check("mem_valid_low", 32'(mem_req_valid), 32'd0);
        if (flushed) model_flush();
    endtask

    task automatic do_idle_flush(input logic [15:0] a);
        @(negedge clk);
        flush         = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        @(negedge clk);
        flush         = 1'b0;
        cpu_req_valid = 1'b0;
        check("flush_no_res", 32'(cpu_res_ready), 32'd0);
        check("flush_no_fill", 32'(mem_req_valid), 32'd0);
        model_flush();
    endtask

    initial begin
        logic [15:0] ra;
        int          r;
        rst = 1'b1; cpu_req_addr = 16'h0000; cpu_req_valid = 1'b0; flush = 1'b0;
        mem_data = 32'h0; mem_ready = 1'b0;
        model_flush();
        exp_hit = 0; exp_miss = 0;
        repeat (3) @(negedge clk);
        check("rst_res_ready", 32'(cpu_res_ready), 32'd0);
        check("rst_res_data", 32'(cpu_res_data), 32'd0);
        check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_req_addr), 32'd0);
        check("rst_mem_rw", 32'(mem_req_rw), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b0;

        // first miss, then a hit on the upper half of beat 0
        do_req(16'h0000, 0, 1'b0);
        do_req(16'h0001, 0, 1'b0);
        // two ways in set 0, LRU eviction
        do_req(16'h0040, 0, 1'b0);
        do_req(16'h0000, 0, 1'b0);
        do_req(16'h0080, 0, 1'b0);
        do_req(16'h0000, 0, 1'b0);
        do_req(16'h0040, 0, 1'b0);
        // memory stall of 5 cycles during fill
        do_req(16'h0107, 2, 1'b0);
        do_req(16'h0106, 0, 1'b0);
        // flush during fill: answered, then the same address misses
        do_req(16'h0208, 0, 1'b1);
        do_req(16'h0208, 0, 1'b0);
        // flush in idle beats a simultaneous request
        do_idle_flush(16'h0208);
        do_req(16'h0208, 0, 1'b0);

        // reset in the middle of a fill
        @(negedge clk);
        cpu_req_addr  = 16'h0302;
        cpu_req_valid = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        check("midfill_valid", 32'(mem_req_valid), 32'd1);
        mem_data  = {mem_word(16'h0301), mem_word(16'h0300)};
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_mem_addr", 32'(mem_req_addr), 32'd0);
        check("midrst_res_ready", 32'(cpu_res_ready), 32'd0);
        check("midrst_res_data", 32'(cpu_res_data), 32'd0);
        check("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
        @(negedge clk);
        check("midrst_no_res", 32'(cpu_res_ready), 32'd0);
        model_flush();
        exp_hit = 0; exp_miss = 0;
        do_req(16'h0302, 0, 1'b0);

        // randomized traffic over a small address pool to mix hits, misses and evictions
        for (int k = 0; k < 200; k++) begin
            r  = int'($urandom_range(0, 19));
            ra = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            if (r == 0) begin
                do_idle_flush(ra);
            end else begin
                do_req(ra, int'($urandom_range(0, 1)), (r == 1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
